// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage of the 19-bit pipelined CPU.
// Owns the PC, drives the synchronous instruction memory read address and
// loads the IF/ID register. Stall controls come from hazard detection and
// the redirect from EX. Two saturating counters expose stall/flush activity.
//
// The memory read address is the *next* PC, so the memory's own output
// register lines up imem_rdata with the registered pc every cycle. Stalls
// therefore just re-issue the same address and need no extra hold register.
module fetch_stage #(
    parameter int                     ADDR_WIDTH  = 19,
    parameter int                     INSTR_WIDTH = 19,
    parameter logic [ADDR_WIDTH-1:0]  RESET_PC    = '0,
    parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = '0,
    parameter int                     CNT_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   PCWrite,
    input  logic                   IF_IDwrite,
    input  logic                   branch_taken,
    input  logic [ADDR_WIDTH-1:0]  branch_target,
    output logic [ADDR_WIDTH-1:0]  imem_addr,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    output logic [ADDR_WIDTH-1:0]  pc,
    output logic [INSTR_WIDTH-1:0] if_id_instr,
    output logic [ADDR_WIDTH-1:0]  if_id_pc,
    output logic                   if_id_valid,
    output logic [CNT_WIDTH-1:0]   stall_count,
    output logic [CNT_WIDTH-1:0]   flush_count
);

    localparam logic [ADDR_WIDTH-1:0] PC_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0]  CNT_MAX = '1;

    logic [ADDR_WIDTH-1:0] pc_next;
    logic [ADDR_WIDTH-1:0] pc_inc;
    logic                  stall_evt;

    // Sequential successor; natural overflow wraps the top address to 0.
    assign pc_inc = pc + PC_ONE;

    // A stall only counts when it actually held the PC; a redirect wins.
    assign stall_evt = !PCWrite && !branch_taken;

    // Next-PC priority: reset, redirect (beats stall), stall hold, advance.
    always_comb begin
        pc_next = pc_inc;
        if (reset)
            pc_next = RESET_PC;
        else if (branch_taken)
            pc_next = branch_target;
        else if (!PCWrite)
            pc_next = pc;
    end

    // The memory sees pc_next directly, including while reset is held.
    assign imem_addr = pc_next;

    // PC always follows pc_next; hold/redirect are already folded in.
    always_ff @(posedge clk) begin
        pc <= pc_next;
    end

    // IF/ID: reset, flush to a bubble on redirect, load, else hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            if_id_instr <= NOP_INSTR;
            if_id_pc    <= '0;
            if_id_valid <= 1'b0;
        end else if (branch_taken) begin
            if_id_instr <= NOP_INSTR;
            if_id_pc    <= pc;
            if_id_valid <= 1'b0;
        end else if (IF_IDwrite) begin
            if_id_instr <= imem_rdata;
            if_id_pc    <= pc;
            if_id_valid <= 1'b1;
        end
    end

    // Saturating stall counter: cycles where the PC was held by PCWrite.
    always_ff @(posedge clk) begin
        if (reset)
            stall_count <= '0;
        else if (stall_evt && stall_count != CNT_MAX)
            stall_count <= stall_count + CNT_ONE;
    end

    // Saturating flush counter: cycles with a redirect from EX.
    always_ff @(posedge clk) begin
        if (reset)
            flush_count <= '0;
        else if (branch_taken && flush_count != CNT_MAX)
            flush_count <= flush_count + CNT_ONE;
    end

endmodule
